mem_reg: RTL

- MEM/WB pipeline register of the CPU. Sits directly downstream of the memory-access control stage.
- Latches that stage's result (`out`) and miss-alignment flag, together with the EX/MEM control fields, into the MEM/WB register set consumed by writeback and the CPU controller.
- Contains a bus-wait FSM with timeout that raises `busy` (a stall request) while a memory access waits on the bus.
- Converts misalignment and bus timeouts into exception codes.

---
 rtl/mem_reg_pkg.sv | 51 +++++
 rtl/mem_wait_fsm.sv | 93 +++++++++
 rtl/mem_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_reg_pkg.sv
// Shared MEM/WB definitions: field widths, enable polarities, exception
// codes, bus-wait FSM states and the packed MEM/WB register payload.
package mem_reg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 30;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned EXP_W  = 3;

    // Polarity constants shared across the CPU
    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Exception codes
    localparam logic [EXP_W-1:0] EXP_NO_EXP      = 3'h0;
    localparam logic [EXP_W-1:0] EXP_MISS_ALIGN  = 3'h4;
    localparam logic [EXP_W-1:0] EXP_BUS_TIMEOUT = 3'h7;

    // Bus-wait FSM states
    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_WAIT = 1'b1
    } mem_st_e;

    // MEM/WB register payload
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              en;
        logic              br_flag;
        logic [OP_W-1:0]   ctrl_op;
        logic [ADDR_W-1:0] dst_addr;
        logic              gpr_we_;
        logic [EXP_W-1:0]  exp_code;
        logic [DATA_W-1:0] data;
    } mem_wb_t;

    // Bubble: invalid slot, no GPR write, no exception; also the reset value
    localparam mem_wb_t MEM_WB_BUBBLE = '{
        pc:       '0,
        en:       DISABLE,
        br_flag:  DISABLE,
        ctrl_op:  '0,
        dst_addr: '0,
        gpr_we_:  DISABLE_,
        exp_code: EXP_NO_EXP,
        data:     '0
    };

endpackage

// File: rtl/mem_wait_fsm.sv
// Bus-wait FSM with saturating timeout counter.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   i_flush       - forces IDLE and clears the counter
//   i_acc_req     - valid bus access this cycle
//   i_rdy_        - bus ready, active low
//   o_busy_c      - combinational stall request while waiting on the bus
//   o_timeout_c   - combinational pulse when the wait budget is exhausted
module mem_wait_fsm
    import mem_reg_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned TO_CNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_flush,
    input  logic i_acc_req,
    input  logic i_rdy_,
    output logic o_busy_c,
    output logic o_timeout_c
);

    localparam logic [TO_CNT_W-1:0] CNT_LIMIT = TO_CNT_W'(WAIT_TIMEOUT);
    localparam logic [TO_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TO_CNT_W-1:0] CNT_ONE   = TO_CNT_W'(1);

    mem_st_e             r_state;
    mem_st_e             w_state_nxt;
    logic [TO_CNT_W-1:0] r_cnt;
    logic [TO_CNT_W-1:0] w_cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MEM_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and stall/timeout outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy_c    = 1'b0;
        o_timeout_c = 1'b0;

        case (r_state)
            MEM_ST_IDLE: begin
                // Zero-wait accesses complete here without stalling
                if (i_acc_req && i_rdy_) begin
                    w_state_nxt = MEM_ST_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                    o_busy_c    = 1'b1;
                end
            end
            MEM_ST_WAIT: begin
                o_busy_c = i_rdy_;
                if (!i_rdy_) begin
                    w_state_nxt = MEM_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LIMIT) begin
                    // Release the stall so the timeout exception gets captured
                    w_state_nxt = MEM_ST_IDLE;
                    w_cnt_nxt   = '0;
                    o_busy_c    = 1'b0;
                    o_timeout_c = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = MEM_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (i_flush) begin
            w_state_nxt = MEM_ST_IDLE;
            w_cnt_nxt   = '0;
        end

        // Stall request drops in the reset cycle itself
        if (reset) begin
            o_busy_c    = 1'b0;
            o_timeout_c = 1'b0;
        end
    end

endmodule

// File: rtl/mem_reg.sv
// MEM/WB pipeline register: captures the memory-access result and EX/MEM
// control fields, stalls on slow bus accesses and folds misalignment and
// bus timeouts into the exception code.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   stall, flush          - controller hold / bubble insertion
//   mem_out_in            - memory-access result
//   miss_align            - misaligned-access flag
//   as_, rdy_             - bus address strobe / ready, active low
//   ex_*                  - EX/MEM register fields
//   busy                  - combinational stall request to the controller
//   mem_*                 - registered MEM/WB fields
module mem_reg
    import mem_reg_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned TO_CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_out_in,
    input  logic              miss_align,
    input  logic              as_,
    input  logic              rdy_,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [OP_W-1:0]   ex_ctrl_op,
    input  logic [ADDR_W-1:0] ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [EXP_W-1:0]  ex_exp_code,
    output logic              busy,
    output logic [PC_W-1:0]   mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [OP_W-1:0]   mem_ctrl_op,
    output logic [ADDR_W-1:0] mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [EXP_W-1:0]  mem_exp_code,
    output logic [DATA_W-1:0] mem_out
);

    logic             w_acc_req;
    logic             w_timeout;
    logic [EXP_W-1:0] w_exp_code;
    mem_wb_t          r_wb;
    mem_wb_t          w_wb_nxt;

    assign w_acc_req = ex_en & ~as_;

    mem_wait_fsm #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .TO_CNT_W     (TO_CNT_W)
    ) u_wait_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (flush),
        .i_acc_req   (w_acc_req),
        .i_rdy_      (rdy_),
        .o_busy_c    (busy),
        .o_timeout_c (w_timeout)
    );

    // Exception select: upstream code beats local detection
    always_comb begin
        w_exp_code = EXP_NO_EXP;
        if (ex_exp_code != EXP_NO_EXP) begin
            w_exp_code = ex_exp_code;
        end else if (miss_align) begin
            w_exp_code = EXP_MISS_ALIGN;
        end else if (w_timeout) begin
            w_exp_code = EXP_BUS_TIMEOUT;
        end
    end

    // Register next value: flush > hold > exception > normal
    always_comb begin
        w_wb_nxt = r_wb;
        if (flush) begin
            w_wb_nxt = MEM_WB_BUBBLE;
        end else if (stall || busy) begin
            w_wb_nxt = r_wb;
        end else if (w_exp_code != EXP_NO_EXP) begin
            // Faulting instruction stays valid for the controller but never writes back
            w_wb_nxt.pc       = ex_pc;
            w_wb_nxt.en       = ENABLE;
            w_wb_nxt.br_flag  = DISABLE;
            w_wb_nxt.ctrl_op  = ex_ctrl_op;
            w_wb_nxt.dst_addr = ex_dst_addr;
            w_wb_nxt.gpr_we_  = DISABLE_;
            w_wb_nxt.exp_code = w_exp_code;
            w_wb_nxt.data     = '0;
        end else begin
            w_wb_nxt.pc       = ex_pc;
            w_wb_nxt.en       = ex_en;
            w_wb_nxt.br_flag  = ex_br_flag;
            w_wb_nxt.ctrl_op  = ex_ctrl_op;
            w_wb_nxt.dst_addr = ex_dst_addr;
            w_wb_nxt.gpr_we_  = ex_gpr_we_;
            w_wb_nxt.exp_code = EXP_NO_EXP;
            w_wb_nxt.data     = mem_out_in;
        end
    end

    // MEM/WB register bank
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb <= MEM_WB_BUBBLE;
        end else begin
            r_wb <= w_wb_nxt;
        end
    end

    assign mem_pc       = r_wb.pc;
    assign mem_en       = r_wb.en;
    assign mem_br_flag  = r_wb.br_flag;
    assign mem_ctrl_op  = r_wb.ctrl_op;
    assign mem_dst_addr = r_wb.dst_addr;
    assign mem_gpr_we_  = r_wb.gpr_we_;
    assign mem_exp_code = r_wb.exp_code;
    assign mem_out      = r_wb.data;

endmodule
